// File: rtl/dma_bus_arbiter_pkg.sv
// rtl/dma_bus_arbiter_pkg.sv - shared types, defaults and need-condition helper for the DMA bus arbiter
//
// Contents:
//   arb_state_t     3-bit state encoding ARB_IDLE..ARB_HOLDOFF
//   DEF_*           default MAX_CYCLES / HOLDOFF / TIMEOUT values
//   *_W             counter widths
//   arb_need()      decides from FIFO/DMA status whether DMA wants the bus
package dma_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE      = 3'd0,
        ARB_REQ       = 3'd1,
        ARB_WAIT_IDLE = 3'd2,
        ARB_OWN       = 3'd3,
        ARB_RELEASE   = 3'd4,
        ARB_HOLDOFF   = 3'd5
    } arb_state_t;

    localparam int DEF_MAX_CYCLES = 8;
    localparam int DEF_HOLDOFF    = 4;
    localparam int DEF_TIMEOUT    = 64;

    localparam int TENURE_W  = 8;
    localparam int HOLD_W    = 8;
    localparam int TIMEOUT_W = 16;

    // SCSI->memory needs the bus when the FIFO is full or a flush has data
    // left; memory->SCSI needs it to refill an empty FIFO unless the final
    // word is already on its way.
    function automatic logic arb_need(
        input logic dmaena,
        input logic dmadir,
        input logic fifo_empty,
        input logic fifo_full,
        input logic flush_fifo,
        input logic last_word
    );
        arb_need = dmaena & (dmadir ? (fifo_full | (flush_fifo & ~fifo_empty))
                                    : (fifo_empty & ~last_word));
    endfunction

endpackage

// File: rtl/dma_bus_arbiter_sat_counter.sv
// rtl/dma_bus_arbiter_sat_counter.sv - loadable up-counter that saturates at all-ones
//
// Ports:
//   clk         in  clock, rising edge
//   rst         in  synchronous reset, active-high (count -> 0)
//   load        in  load load_value (wins over enable)
//   load_value  in  WIDTH value to load
//   enable      in  increment by one unless already saturated
//   count       out current count
module arb_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - 68030 bus-mastership sequencer for the SCSI DMA engine
//
// Optional feature macro: ARB_TIMEOUT_EN (withdraw the request after TIMEOUT
// clocks without a usable grant and flag ARB_TMO). Default build: wait forever.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   DMAENA, DMADIR           DMA enable, direction (1 = SCSI->memory)
//   FIFOEMPTY, FIFOFULL      FIFO status
//   FLUSHFIFO, LASTWORD      flush request, final word in flight
//   CYCLEDONE                one-clock pulse per completed DMA bus cycle
//   BG_                      bus grant from CPU (active-low, synchronised)
//   BGACK_I_, AS_I_          observed BGACK_ / AS_ on the bus (active-low)
//   BR_                      bus request (active-low)
//   BGACK_O_, BGACK_OE       BGACK_ drive and its output enable
//   BGRANT_                  low while DMA owns the bus
//   ARB_TMO                  sticky grant-timeout flag
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int HOLDOFF    = DEF_HOLDOFF,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic CLK,
    input  logic RST,
    input  logic DMAENA,
    input  logic DMADIR,
    input  logic FIFOEMPTY,
    input  logic FIFOFULL,
    input  logic FLUSHFIFO,
    input  logic LASTWORD,
    input  logic CYCLEDONE,
    input  logic BG_,
    input  logic BGACK_I_,
    input  logic AS_I_,
    output logic BR_,
    output logic BGACK_O_,
    output logic BGACK_OE,
    output logic BGRANT_,
    output logic ARB_TMO
);

    if (MAX_CYCLES < 1 || MAX_CYCLES > 255 || HOLDOFF < 0 || HOLDOFF > 255 || TIMEOUT < 1)
    begin : g_param_check
        $error("dma_bus_arbiter: parameter out of range");
    end

    localparam logic [TENURE_W-1:0]  TEN_LAST  = TENURE_W'(MAX_CYCLES - 1);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);

    arb_state_t state, next_state;

    logic need;
    logic bus_idle;
    logic tmo_hit;

    logic [TENURE_W-1:0] ten_cnt;
    logic [HOLD_W-1:0]   hold_cnt;

    logic br_d, bgack_o_d, bgack_oe_d, bgrant_d;

    assign need     = arb_need(DMAENA, DMADIR, FIFOEMPTY, FIFOFULL, FLUSHFIFO, LASTWORD);
    assign bus_idle = AS_I_ & BGACK_I_;

    // Tenure counter held at zero outside OWN so it is clear on entry.
    arb_sat_counter #(.WIDTH(TENURE_W)) u_tenure_cnt (
        .clk        (CLK),
        .rst        (RST),
        .load       (state != ARB_OWN),
        .load_value ('0),
        .enable     (CYCLEDONE),
        .count      (ten_cnt)
    );

    arb_sat_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
        .clk        (CLK),
        .rst        (RST),
        .load       (state != ARB_HOLDOFF),
        .load_value ('0),
        .enable     (1'b1),
        .count      (hold_cnt)
    );

`ifdef ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT - 1);

    logic                 waiting;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic                 arb_tmo_q;

    // Bouncing between REQ and WAIT_IDLE keeps counting: the whole wait
    // for a usable grant is bounded, not each half of it.
    assign waiting = (state == ARB_REQ) || (state == ARB_WAIT_IDLE);

    arb_sat_counter #(.WIDTH(TIMEOUT_W)) u_tmo_cnt (
        .clk        (CLK),
        .rst        (RST),
        .load       (!waiting),
        .load_value ('0),
        .enable     (1'b1),
        .count      (tmo_cnt)
    );

    assign tmo_hit = waiting && (tmo_cnt == TMO_LAST);

    always_ff @(posedge CLK) begin
        if (RST || !DMAENA) begin
            arb_tmo_q <= 1'b0;
        end else if (tmo_hit) begin
            arb_tmo_q <= 1'b1;
        end
    end

    assign ARB_TMO = arb_tmo_q;
`else
    assign tmo_hit = 1'b0;
    assign ARB_TMO = 1'b0;
`endif

    // State register; outputs are registered from the next state so they
    // change on the same edge as the state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ARB_IDLE;
            BR_      <= 1'b1;
            BGACK_O_ <= 1'b1;
            BGACK_OE <= 1'b0;
            BGRANT_  <= 1'b1;
        end else begin
            state    <= next_state;
            BR_      <= br_d;
            BGACK_O_ <= bgack_o_d;
            BGACK_OE <= bgack_oe_d;
            BGRANT_  <= bgrant_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE: begin
                if (need) next_state = ARB_REQ;
            end
            // Losing the need wins over a grant arriving on the same clock.
            // A grant onto an idle bus goes straight to OWN so BGACK_ follows
            // BG_ by one clock.
            ARB_REQ: begin
                if (!need)                 next_state = ARB_IDLE;
                else if (!BG_ && bus_idle) next_state = ARB_OWN;
                else if (!BG_)             next_state = ARB_WAIT_IDLE;
                else if (tmo_hit)          next_state = ARB_HOLDOFF;
            end
            ARB_WAIT_IDLE: begin
                if (BG_)           next_state = ARB_REQ;
                else if (bus_idle) next_state = ARB_OWN;
                else if (tmo_hit)  next_state = ARB_HOLDOFF;
            end
            // Release only at a cycle boundary. With DMA disabled and no
            // cycle on the bus there is nothing to wait for.
            ARB_OWN: begin
                if (CYCLEDONE && ((ten_cnt >= TEN_LAST) || !need))
                    next_state = ARB_RELEASE;
                else if (!DMAENA && AS_I_)
                    next_state = ARB_RELEASE;
            end
            ARB_RELEASE: begin
                next_state = ARB_HOLDOFF;
            end
            ARB_HOLDOFF: begin
                if (hold_cnt >= HOLD_LAST) next_state = ARB_IDLE;
            end
            default: begin
                next_state = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        br_d       = 1'b1;
        bgack_o_d  = 1'b1;
        bgack_oe_d = 1'b0;
        bgrant_d   = 1'b1;
        case (next_state)
            ARB_REQ, ARB_WAIT_IDLE: begin
                br_d = 1'b0;
            end
            ARB_OWN: begin
                bgack_o_d  = 1'b0;
                bgack_oe_d = 1'b1;
                bgrant_d   = 1'b0;
            end
            // Drive BGACK_ high for one clock before tristating it.
            ARB_RELEASE: begin
                bgack_oe_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb/tb_dma_bus_arbiter.sv - directed self-checking bench for dma_bus_arbiter (default build)
module tb_dma_bus_arbiter;

    logic CLK = 1'b0;
    logic RST, DMAENA, DMADIR, FIFOEMPTY, FIFOFULL, FLUSHFIFO, LASTWORD, CYCLEDONE;
    logic BG_, BGACK_I_, AS_I_;
    logic BR_, BGACK_O_, BGACK_OE, BGRANT_, ARB_TMO;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 CLK = ~CLK;

    dma_bus_arbiter #(
        .MAX_CYCLES (8),
        .HOLDOFF    (4),
        .TIMEOUT    (64)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .DMAENA    (DMAENA),
        .DMADIR    (DMADIR),
        .FIFOEMPTY (FIFOEMPTY),
        .FIFOFULL  (FIFOFULL),
        .FLUSHFIFO (FLUSHFIFO),
        .LASTWORD  (LASTWORD),
        .CYCLEDONE (CYCLEDONE),
        .BG_       (BG_),
        .BGACK_I_  (BGACK_I_),
        .AS_I_     (AS_I_),
        .BR_       (BR_),
        .BGACK_O_  (BGACK_O_),
        .BGACK_OE  (BGACK_OE),
        .BGRANT_   (BGRANT_),
        .ARB_TMO   (ARB_TMO)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change before a falling edge; outputs are sampled at the falling
    // edge, i.e. half a clock after the rising edge that updated them.
    task automatic step();
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1; DMAENA = 1'b0; DMADIR = 1'b1; FIFOEMPTY = 1'b1; FIFOFULL = 1'b0;
        FLUSHFIFO = 1'b0; LASTWORD = 1'b0; CYCLEDONE = 1'b0;
        BG_ = 1'b1; BGACK_I_ = 1'b1; AS_I_ = 1'b1;
        step(); step();
        RST = 1'b0;

        check_eq("rst_br",       BR_,      1'b1);
        check_eq("rst_bgack_o",  BGACK_O_, 1'b1);
        check_eq("rst_bgack_oe", BGACK_OE, 1'b0);
        check_eq("rst_bgrant",   BGRANT_,  1'b1);
        check_eq("rst_tmo",      ARB_TMO,  1'b0);

        // FIFO full, SCSI->memory: request, grant 3 clocks later onto an idle bus.
        DMAENA = 1'b1; FIFOFULL = 1'b1; FIFOEMPTY = 1'b0;
        step();
        check_eq("req_br", BR_, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("req_hold_br",    BR_,      1'b0);
            check_eq("req_hold_bgack", BGACK_O_, 1'b1);
        end
        BG_ = 1'b0;
        step();
        check_eq("own_bgack_o",  BGACK_O_, 1'b0);
        check_eq("own_bgrant",   BGRANT_,  1'b0);
        check_eq("own_br",       BR_,      1'b1);
        check_eq("own_bgack_oe", BGACK_OE, 1'b1);
        BG_ = 1'b1;

        // Eight cycles with need held: released right after the eighth.
        for (int i = 0; i < 8; i++) begin
            CYCLEDONE = 1'b1;
            step();
            CYCLEDONE = 1'b0;
            if (i < 7) begin
                check_eq("tenure_bgack_o", BGACK_O_, 1'b0);
                step();
                check_eq("tenure_gap_bgrant", BGRANT_, 1'b0);
            end
        end
        check_eq("rel_bgack_o",  BGACK_O_, 1'b1);
        check_eq("rel_bgack_oe", BGACK_OE, 1'b1);
        check_eq("rel_bgrant",   BGRANT_,  1'b1);
        step();
        check_eq("hold_bgack_oe", BGACK_OE, 1'b0);
        check_eq("hold_br0", BR_, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("hold_br", BR_, 1'b1);
        end
        step();
        check_eq("rereq_br", BR_, 1'b0);

        // Grant while another master's cycle is on the bus: wait for AS_ to rise.
        AS_I_ = 1'b0; BG_ = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("wait_bgack_o", BGACK_O_, 1'b1);
            check_eq("wait_br",      BR_,      1'b0);
        end
        AS_I_ = 1'b1;
        step();
        check_eq("wait_own_bgack_o", BGACK_O_, 1'b0);
        BG_ = 1'b1;

        // DMAENA drops mid-cycle: hold the bus until that cycle completes.
        AS_I_ = 1'b0; DMAENA = 1'b0;
        step();
        check_eq("dis_bgrant1", BGRANT_, 1'b0);
        step();
        check_eq("dis_bgrant2", BGRANT_, 1'b0);
        CYCLEDONE = 1'b1;
        step();
        CYCLEDONE = 1'b0; AS_I_ = 1'b1;
        check_eq("dis_rel_bgrant",  BGRANT_,  1'b1);
        check_eq("dis_rel_bgack_o", BGACK_O_, 1'b1);
        check_eq("dis_rel_oe",      BGACK_OE, 1'b1);
        step();
        check_eq("dis_hold_oe", BGACK_OE, 1'b0);
        for (int i = 0; i < 6; i++) step();
        check_eq("dis_idle_br", BR_, 1'b1);

        // Need drops in REQ on the same clock BG_ arrives: back to IDLE.
        DMAENA = 1'b1;
        step();
        check_eq("drop_req_br", BR_, 1'b0);
        FIFOFULL = 1'b0; BG_ = 1'b0;
        step();
        check_eq("drop_br",      BR_,      1'b1);
        check_eq("drop_bgack_o", BGACK_O_, 1'b1);
        BG_ = 1'b1;

        // Memory->SCSI: empty FIFO needs the bus unless the last word is in flight.
        DMADIR = 1'b0; FIFOEMPTY = 1'b1; LASTWORD = 1'b1;
        step();
        check_eq("lastword_br", BR_, 1'b1);
        LASTWORD = 1'b0;
        step();
        check_eq("m2s_br", BR_, 1'b0);

        // Reset while owning the bus.
        BG_ = 1'b0;
        step();
        check_eq("pre_rst_bgrant", BGRANT_, 1'b0);
        RST = 1'b1;
        step();
        check_eq("own_rst_br",      BR_,      1'b1);
        check_eq("own_rst_oe",      BGACK_OE, 1'b0);
        check_eq("own_rst_bgrant",  BGRANT_,  1'b1);
        check_eq("own_rst_bgack_o", BGACK_O_, 1'b1);
        check_eq("own_rst_tmo",     ARB_TMO,  1'b0);
        RST = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
